// File: rtl/usb_cmd_parser_pkg.sv
// Shared definitions for the USB command parser: FSM states, error codes and defaults.
package usb_cmd_parser_pkg;

  // Parser states; transitions only happen when a FIFO byte arrives (or on timeout).
  typedef enum logic [2:0] {
    StHunt,
    StCmd,
    StLen,
    StPayload,
    StCsum
  } state_e;

  // err_code values reported alongside a frame_err pulse.
  localparam logic [1:0] ErrLen  = 2'd1;
  localparam logic [1:0] ErrCsum = 2'd2;
  localparam logic [1:0] ErrTmo  = 2'd3;

  // Default frame start marker.
  localparam logic [7:0] DefaultSyncByte = 8'hA5;

  // Running checksum update: plain XOR fold.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/usb_fifo_byte_reader.sv
// Non-show-ahead FIFO pop handshake: one outstanding read at a time.
// A read is issued, then the byte is presented as byte_vld/byte_data the following cycle.
module usb_fifo_byte_reader (
  input  logic       clk50,
  input  logic       RST,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  input  logic       want_byte,
  output logic       rx_rdreq,
  output logic       byte_vld,
  output logic [7:0] byte_data
);

  logic rd_pending_q;

  // Issue a read only when the FIFO has data, no read is in flight and the parser can accept it.
  // RST gating keeps rdreq low while the parser is held in reset.
  always_comb begin
    rx_rdreq = !RST && want_byte && !rx_empty && !rd_pending_q;
  end

  // rd_pending marks the cycle in which rx_data carries the popped byte.
  always_ff @(posedge clk50) begin
    if (RST) begin
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= rx_rdreq;
    end
  end

  always_comb begin
    byte_vld  = rd_pending_q;
    byte_data = rx_data;
  end

endmodule

// File: rtl/usb_cmd_parser.sv
// Framed command parser: SYNC, CMD, LEN, LEN payload bytes, CSUM (XOR of CMD..payload).
// Emits a header strobe, a back-pressured payload stream and a good/bad pulse per frame.
module usb_cmd_parser
  import usb_cmd_parser_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = DefaultSyncByte,
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk50,
  input  logic        RST,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        rx_rdreq,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [7:0]  cmd_len,
  output logic        pl_valid,
  output logic [7:0]  pl_data,
  output logic        pl_last,
  input  logic        pl_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);
  // LEN is a byte, so MAX_LEN is only meaningful up to 255.
  localparam logic [7:0]        MaxLen    = 8'(MAX_LEN);

  state_e              state_q;
  logic [7:0]          cmd_byte_q;   // CMD held back until LEN is accepted
  logic [7:0]          csum_q;
  logic [7:0]          remain_q;     // payload bytes still to come
  logic [TimerW-1:0]   timer_q;

  logic                cmd_valid_q;
  logic [7:0]          cmd_code_q;
  logic [7:0]          cmd_len_q;
  logic                pl_valid_q;
  logic [7:0]          pl_data_q;
  logic                pl_last_q;
  logic                frame_ok_q;
  logic                frame_err_q;
  logic [1:0]          err_code_q;
  logic [15:0]         frame_cnt_q;

  logic                stall;
  logic                in_frame;
  logic                tmo_hit;
  logic                byte_vld;
  logic [7:0]          byte_data;

  // A held payload byte blocks new reads so nothing is ever overwritten.
  always_comb begin
    stall    = pl_valid_q && !pl_ready;
    in_frame = (state_q != StHunt);
    tmo_hit  = in_frame && !byte_vld && !stall && (timer_q == TimerLast);
  end

  usb_fifo_byte_reader u_reader (
    .clk50     (clk50),
    .RST       (RST),
    .rx_empty  (rx_empty),
    .rx_data   (rx_data),
    .want_byte (!stall),
    .rx_rdreq  (rx_rdreq),
    .byte_vld  (byte_vld),
    .byte_data (byte_data)
  );

  // Inter-byte timer: idle in HUNT, cleared by each byte, frozen while the consumer stalls.
  always_ff @(posedge clk50) begin
    if (RST) begin
      timer_q <= '0;
    end else if (!in_frame || byte_vld || tmo_hit) begin
      timer_q <= '0;
    end else if (!stall) begin
      timer_q <= timer_q + TimerW'(1);
    end
  end

  // Frame FSM with registered header, payload and status outputs.
  always_ff @(posedge clk50) begin
    if (RST) begin
      state_q     <= StHunt;
      cmd_byte_q  <= '0;
      csum_q      <= '0;
      remain_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_len_q   <= '0;
      pl_valid_q  <= 1'b0;
      pl_data_q   <= '0;
      pl_last_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (pl_valid_q && pl_ready) begin
        pl_valid_q <= 1'b0;
        pl_last_q  <= 1'b0;
      end

      if (tmo_hit) begin
        // Any outstanding payload byte is left in place for the consumer.
        state_q     <= StHunt;
        frame_err_q <= 1'b1;
        err_code_q  <= ErrTmo;
      end else if (byte_vld) begin
        unique case (state_q)
          StHunt: begin
            if (byte_data == SYNC_BYTE) begin
              state_q <= StCmd;
            end
          end
          StCmd: begin
            cmd_byte_q <= byte_data;
            csum_q     <= byte_data;
            state_q    <= StLen;
          end
          StLen: begin
            if (byte_data > MaxLen) begin
              state_q     <= StHunt;
              frame_err_q <= 1'b1;
              err_code_q  <= ErrLen;
            end else begin
              cmd_code_q  <= cmd_byte_q;
              cmd_len_q   <= byte_data;
              cmd_valid_q <= 1'b1;
              csum_q      <= csum_fold(csum_q, byte_data);
              remain_q    <= byte_data;
              state_q     <= (byte_data == 8'd0) ? StCsum : StPayload;
            end
          end
          StPayload: begin
            pl_valid_q <= 1'b1;
            pl_data_q  <= byte_data;
            pl_last_q  <= (remain_q == 8'd1);
            csum_q     <= csum_fold(csum_q, byte_data);
            remain_q   <= remain_q - 8'd1;
            if (remain_q == 8'd1) begin
              state_q <= StCsum;
            end
          end
          StCsum: begin
            if (byte_data == csum_q) begin
              frame_ok_q  <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ErrCsum;
            end
            state_q <= StHunt;
          end
          default: begin
            state_q <= StHunt;
          end
        endcase
      end
    end
  end

  always_comb begin
    cmd_valid = cmd_valid_q;
    cmd_code  = cmd_code_q;
    cmd_len   = cmd_len_q;
    pl_valid  = pl_valid_q;
    pl_data   = pl_data_q;
    pl_last   = pl_last_q;
    frame_ok  = frame_ok_q;
    frame_err = frame_err_q;
    err_code  = err_code_q;
    busy      = in_frame;
    frame_cnt = frame_cnt_q;
  end

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Directed scoreboard bench for usb_cmd_parser with a behavioural non-show-ahead FIFO.
module tb_usb_cmd_parser;

  localparam int unsigned Tmo = 1000;

  logic        clk50 = 1'b0;
  logic        RST;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rx_rdreq;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [7:0]  cmd_len;
  logic        pl_valid;
  logic [7:0]  pl_data;
  logic        pl_last;
  logic        pl_ready;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  logic [7:0]  fifo[$];
  logic [15:0] exp_cmd[$];  // {code, len}
  logic [8:0]  exp_pl[$];   // {last, data}
  logic [2:0]  exp_fr[$];   // {ok, err_code}

  always #10 clk50 = ~clk50;

  usb_cmd_parser #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (64),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .clk50     (clk50),
    .RST       (RST),
    .rx_empty  (rx_empty),
    .rx_data   (rx_data),
    .rx_rdreq  (rx_rdreq),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_len   (cmd_len),
    .pl_valid  (pl_valid),
    .pl_data   (pl_data),
    .pl_last   (pl_last),
    .pl_ready  (pl_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    fifo.push_back(b);
    rx_empty = 1'b0;
  endtask

  // Compare registered DUT outputs against the scoreboard; inputs are settled at this point.
  task automatic monitor();
    logic [15:0] ec;
    logic [8:0]  ep;
    logic [2:0]  ef;
    if (cmd_valid) begin
      if (exp_cmd.size() == 0) chk("cmd_unexpected", 32'(cmd_valid), 32'(0));
      else begin
        ec = exp_cmd.pop_front();
        chk("cmd_code", 32'(cmd_code), 32'(ec[15:8]));
        chk("cmd_len", 32'(cmd_len), 32'(ec[7:0]));
      end
    end
    if (pl_valid && pl_ready) begin
      if (exp_pl.size() == 0) chk("pl_unexpected", 32'(pl_data), 32'h100);
      else begin
        ep = exp_pl.pop_front();
        chk("pl_data", 32'(pl_data), 32'(ep[7:0]));
        chk("pl_last", 32'(pl_last), 32'(ep[8]));
      end
    end
    if (frame_ok || frame_err) begin
      chk("ok_err_excl", 32'(frame_ok & frame_err), 32'(0));
      if (exp_fr.size() == 0) chk("frame_unexpected", 32'({frame_ok, err_code}), 32'h8);
      else begin
        ef = exp_fr.pop_front();
        chk("frame_ok_kind", 32'(frame_ok), 32'(ef[2]));
        if (ef[2]) model_cnt++;
        else chk("err_code", 32'(err_code), 32'(ef[1:0]));
        chk("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
      end
    end
  endtask

  // One clock: monitor, advance, then model the FIFO's registered read port.
  task automatic tick();
    logic rd;
    if (!RST) monitor();
    rd = rx_rdreq;
    if (rd) chk("rdreq_nonempty", 32'(rx_empty), 32'(0));
    @(posedge clk50);
    #1;
    if (rd && fifo.size() > 0) rx_data = fifo.pop_front();
    rx_empty = (fifo.size() == 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo.size() != 0 || exp_cmd.size() != 0 || exp_pl.size() != 0 ||
            exp_fr.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'(1));
    repeat (8) tick();
    chk("idle_busy", 32'(busy), 32'(0));
  endtask

  task automatic t1_frame();
    put(8'hA5); put(8'h10); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h13);
    exp_cmd.push_back({8'h10, 8'h03});
    exp_pl.push_back({1'b0, 8'h11});
    exp_pl.push_back({1'b0, 8'h22});
    exp_pl.push_back({1'b1, 8'h33});
    exp_fr.push_back(3'b100);
  endtask

  initial begin
    int n;
    RST = 1'b1;
    rx_empty = 1'b1;
    rx_data = 8'h00;
    pl_ready = 1'b1;
    repeat (3) tick();
    chk("rst_rdreq", 32'(rx_rdreq), 32'(0));
    chk("rst_pl_valid", 32'(pl_valid), 32'(0));
    chk("rst_cmd_code", 32'(cmd_code), 32'(0));
    chk("rst_err_code", 32'(err_code), 32'(0));
    chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    RST = 1'b0;

    // T1 good frame
    t1_frame();
    drain(200);

    // T2 junk then zero-length frame
    put(8'h00); put(8'hFF); put(8'hA5); put(8'h20); put(8'h00); put(8'h20);
    exp_cmd.push_back({8'h20, 8'h00});
    exp_fr.push_back(3'b100);
    drain(200);

    // T3 bad checksum: 10^01^55=44, 00 sent
    put(8'hA5); put(8'h10); put(8'h01); put(8'h55); put(8'h00);
    exp_cmd.push_back({8'h10, 8'h01});
    exp_pl.push_back({1'b1, 8'h55});
    exp_fr.push_back({1'b0, 2'd2});
    drain(200);

    // T4 oversize LEN then a good frame
    put(8'hA5); put(8'h10); put(8'h41);
    exp_fr.push_back({1'b0, 2'd1});
    put(8'hA5); put(8'h30); put(8'h00); put(8'h30);
    exp_cmd.push_back({8'h30, 8'h00});
    exp_fr.push_back(3'b100);
    drain(200);

    // T5 backpressure on payload byte 22
    t1_frame();
    n = 0;
    while (!(pl_valid && pl_data == 8'h22) && n < 100) begin
      tick();
      n++;
    end
    chk("bp_reach_22", 32'(n < 100), 32'(1));
    pl_ready = 1'b0;
    repeat (20) begin
      tick();
      chk("bp_hold_valid", 32'(pl_valid), 32'(1));
      chk("bp_hold_data", 32'(pl_data), 32'h22);
      chk("bp_no_rdreq", 32'(rx_rdreq), 32'(0));
    end
    pl_ready = 1'b1;
    drain(200);

    // T6a timeout after A5 10
    put(8'hA5); put(8'h10);
    exp_fr.push_back({1'b0, 2'd3});
    drain(Tmo + 100);

    // T6b reset mid-payload, then a fresh T1 frame
    pl_ready = 1'b0;
    put(8'hA5); put(8'h10); put(8'h03); put(8'h11);
    exp_cmd.push_back({8'h10, 8'h03});
    n = 0;
    while (!pl_valid && n < 100) begin
      tick();
      n++;
    end
    chk("mid_pl_valid", 32'(pl_valid), 32'(1));
    chk("mid_pl_data", 32'(pl_data), 32'h11);
    RST = 1'b1;
    tick();
    chk("mrst_pl_valid", 32'(pl_valid), 32'(0));
    chk("mrst_cmd_len", 32'(cmd_len), 32'(0));
    chk("mrst_frame_cnt", 32'(frame_cnt), 32'(0));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_rdreq", 32'(rx_rdreq), 32'(0));
    RST = 1'b0;
    model_cnt = 0;
    pl_ready = 1'b1;
    repeat (4) tick();
    chk("mrst_no_err", 32'(err_code), 32'(0));
    t1_frame();
    drain(200);
    chk("final_cnt", 32'(frame_cnt), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
